spi_frame_iff: RTL and testbench

SPI_FRAME_IFF -- requirements
Module: spi_frame_iff

---
 rtl/spi_pkg.sv | 32 +++
 rtl/sync_sig.sv | 26 ++
 rtl/spi_frame_iff.sv | 153 +++++++++++++++
 tb/tb_spi_frame_iff.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame interface.
//   spi_state_t    : frame FSM states
//   spi_ev_t       : per-cycle registered SPI events (ss edges, sample/shift edges)
//   CPOL_* / CPHA_*: clock polarity / phase encodings
//   sample_on_rise : true when the sample edge is a rising spi_clk transition
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_END    = 2'd2
  } spi_state_t;

  localparam logic CPOL_IDLE_LOW  = 1'b0;
  localparam logic CPOL_IDLE_HIGH = 1'b1;
  localparam logic CPHA_LEAD      = 1'b0;
  localparam logic CPHA_TRAIL     = 1'b1;

  typedef struct packed {
    logic ss_rise;
    logic ss_fall;
    logic sample;
    logic shift;
  } spi_ev_t;

  // Leading edge is rising for CPOL low; sampling on leading edge for CPHA lead.
  // Both "true" or both "false" means the sample edge is a rising one.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return (cpol == CPOL_IDLE_LOW) == (cpha == CPHA_LEAD);
  endfunction

endpackage

// File: rtl/sync_sig.sv
// Two-flop synchroniser for one asynchronous input.
//   clk, nrst : system clock, synchronous active-low reset
//   d         : asynchronous input
//   q         : synchronised output (both flops reset to RST_VAL)
module sync_sig #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_frame_iff.sv
// SPI slave frame interface: receives an RX_W-bit MOSI word and sends a
// TX_W-bit MISO word per spi_ss frame, all in the clk domain.
//   clk, nrst          : system clock, synchronous active-low reset
//   spi_clk/ss/mosi    : asynchronous SPI master inputs (ss active-low)
//   spi_miso           : serial data to master
//   tx_data / tx_taken : word for next frame / pulse when it is captured
//   rx_data / rx_valid : last complete word / pulse when it updates
//   rx_len             : bit count of last frame, saturating at RX_W+1
//   frame_err          : pulse when a frame ends with rx_len != RX_W
module spi_frame_iff
  import spi_pkg::*;
#(
  parameter int   RX_W = 56,
  parameter int   TX_W = 48,
  parameter logic CPOL = 1'b0,
  parameter logic CPHA = 1'b0
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        spi_clk,
  input  logic                        spi_ss,
  input  logic                        spi_mosi,
  output logic                        spi_miso,
  input  logic [TX_W-1:0]             tx_data,
  output logic                        tx_taken,
  output logic [RX_W-1:0]             rx_data,
  output logic                        rx_valid,
  output logic [$clog2(RX_W+2)-1:0]   rx_len,
  output logic                        frame_err
);

  localparam int             LW          = $clog2(RX_W+2);
  localparam logic [LW-1:0]  LEN_FULL    = LW'(RX_W);
  localparam logic [LW-1:0]  LEN_SAT     = LW'(RX_W+1);
  localparam logic           SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

  logic clk_s, ss_s, mosi_s;
  logic clk_last, ss_last, mosi_d;

  sync_sig #(.RST_VAL(CPOL))  u_sync_clk  (.clk(clk), .nrst(nrst), .d(spi_clk),  .q(clk_s));
  sync_sig #(.RST_VAL(1'b1))  u_sync_ss   (.clk(clk), .nrst(nrst), .d(spi_ss),   .q(ss_s));
  sync_sig #(.RST_VAL(1'b0))  u_sync_mosi (.clk(clk), .nrst(nrst), .d(spi_mosi), .q(mosi_s));

  spi_ev_t ev_nxt, ev;
  logic    clk_rise, clk_fall;

  assign clk_rise = clk_s & ~clk_last;
  assign clk_fall = ~clk_s & clk_last;

  always_comb begin
    ev_nxt         = '0;
    ev_nxt.ss_rise = ss_s & ~ss_last;
    ev_nxt.ss_fall = ~ss_s & ss_last;
    ev_nxt.sample  = SAMPLE_RISE ? clk_rise : clk_fall;
    ev_nxt.shift   = SAMPLE_RISE ? clk_fall : clk_rise;
  end

  // Edge-detect stage. mosi_d is delayed alongside so it lines up with the
  // registered sample event. After reset the synchroniser still holds its
  // reset values for two cycles; armed waits until ss has been really seen
  // high, so a master holding ss low across reset cannot start a frame.
  logic [1:0] settle;
  logic       armed;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      clk_last <= CPOL;
      ss_last  <= 1'b1;
      mosi_d   <= 1'b0;
      ev       <= '0;
      settle   <= 2'd0;
      armed    <= 1'b0;
    end else begin
      clk_last <= clk_s;
      ss_last  <= ss_s;
      mosi_d   <= mosi_s;
      ev       <= ev_nxt;
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (settle[1] && ss_s) armed <= 1'b1;
    end
  end

  spi_state_t      state;
  logic [TX_W-1:0] sout;
  logic [RX_W-1:0] sin;
  logic [LW-1:0]   cnt;
  logic            first_shift;
  logic            start_pend;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= ST_IDLE;
      sout        <= '0;
      sin         <= '0;
      cnt         <= '0;
      first_shift <= 1'b0;
      start_pend  <= 1'b0;
      rx_data     <= '0;
      rx_len      <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_taken    <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      tx_taken  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          start_pend <= 1'b0;
          if (armed && (ev.ss_fall || start_pend)) begin
            state       <= ST_ACTIVE;
            sout        <= tx_data;
            tx_taken    <= 1'b1;
            sin         <= '0;
            cnt         <= '0;
            first_shift <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          // ss rising wins over any clock edge seen in the same cycle
          if (ev.ss_rise) begin
            state  <= ST_END;
            rx_len <= cnt;
            if (cnt == LEN_FULL) begin
              rx_data  <= sin;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            if (ev.sample) begin
              sin <= {sin[RX_W-2:0], mosi_d};
              if (cnt != LEN_SAT) cnt <= cnt + LW'(1);
            end
            if (ev.shift) begin
              first_shift <= 1'b0;
              // CPHA=1: MSB is already on the line, first leading edge only arms shifting
              if (!(CPHA == CPHA_TRAIL && first_shift)) sout <= {sout[TX_W-2:0], 1'b0};
            end
          end
        end
        ST_END: begin
          state      <= ST_IDLE;
          start_pend <= ev.ss_fall;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign spi_miso = (state == ST_ACTIVE) & sout[TX_W-1];

endmodule

// File: tb/tb_spi_frame_iff.sv
module tb_spi_frame_iff;
  localparam int RXW = 56;
  localparam int TXW = 48;
  localparam int H   = 6;   // SPI half period in clk cycles

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  // index 0: mode 0, 1: mode 1, 2: mode 3
  logic           sclk[3], ss[3], mosi[3], miso[3], tt[3], rxv[3], ferr[3];
  logic [TXW-1:0] txd[3];
  logic [RXW-1:0] rxd[3];
  logic [5:0]     rxl[3];

  int total = 0;
  int bad   = 0;
  int nv[3], ne[3], nt[3];
  int prot_bad = 0;
  logic [RXW-1:0] rxm[3];
  logic vprev[3], eprev[3], tprev[3];

  spi_frame_iff #(.RX_W(RXW), .TX_W(TXW), .CPOL(1'b0), .CPHA(1'b0)) u0 (
    .clk(clk), .nrst(nrst), .spi_clk(sclk[0]), .spi_ss(ss[0]), .spi_mosi(mosi[0]),
    .spi_miso(miso[0]), .tx_data(txd[0]), .tx_taken(tt[0]), .rx_data(rxd[0]),
    .rx_valid(rxv[0]), .rx_len(rxl[0]), .frame_err(ferr[0]));
  spi_frame_iff #(.RX_W(RXW), .TX_W(TXW), .CPOL(1'b0), .CPHA(1'b1)) u1 (
    .clk(clk), .nrst(nrst), .spi_clk(sclk[1]), .spi_ss(ss[1]), .spi_mosi(mosi[1]),
    .spi_miso(miso[1]), .tx_data(txd[1]), .tx_taken(tt[1]), .rx_data(rxd[1]),
    .rx_valid(rxv[1]), .rx_len(rxl[1]), .frame_err(ferr[1]));
  spi_frame_iff #(.RX_W(RXW), .TX_W(TXW), .CPOL(1'b1), .CPHA(1'b1)) u3 (
    .clk(clk), .nrst(nrst), .spi_clk(sclk[2]), .spi_ss(ss[2]), .spi_mosi(mosi[2]),
    .spi_miso(miso[2]), .tx_data(txd[2]), .tx_taken(tt[2]), .rx_data(rxd[2]),
    .rx_valid(rxv[2]), .rx_len(rxl[2]), .frame_err(ferr[2]));

  // pulse counters and one-cycle / exclusivity watch
  always @(negedge clk) begin
    for (int m = 0; m < 3; m++) begin
      if (rxv[m]  === 1'b1) nv[m]++;
      if (ferr[m] === 1'b1) ne[m]++;
      if (tt[m]   === 1'b1) nt[m]++;
      if ((rxv[m] & ferr[m]) === 1'b1) prot_bad++;
      if (((rxv[m] & vprev[m]) | (ferr[m] & eprev[m]) | (tt[m] & tprev[m])) === 1'b1) prot_bad++;
      vprev[m] = rxv[m];
      eprev[m] = ferr[m];
      tprev[m] = tt[m];
    end
  end

  function automatic logic cpol(input int m);
    return (m == 2);
  endfunction
  function automatic logic cpha(input int m);
    return (m != 0);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one SPI bit as the master: drive mosi, capture miso at the sample edge
  task automatic sbit(input int m, input logic b, output logic mi);
    if (!cpha(m)) begin
      mosi[m] = b;
      wait_n(H);
      mi = miso[m];
      sclk[m] = ~cpol(m);
      wait_n(H);
      sclk[m] = cpol(m);
    end else begin
      sclk[m] = ~cpol(m);
      mosi[m] = b;
      wait_n(H);
      mi = miso[m];
      sclk[m] = cpol(m);
      wait_n(H);
    end
  endtask

  task automatic frame(input int m, input int nb, input logic [63:0] d, input logic [TXW-1:0] tx,
                       input bit lat, input bit ext, output logic [63:0] cap);
    logic mi;
    cap = '0;
    txd[m] = tx;
    @(negedge clk);
    ss[m] = 1'b0;
    if (lat) begin
      repeat (3) @(posedge clk);
      #1 chk("tx_taken_early", tt[m], 0);
      @(posedge clk);
      #1 chk("tx_taken_latency", tt[m], 1);
    end
    wait_n(8);
    for (int i = 0; i < nb; i++) begin
      sbit(m, d[nb-1-i], mi);
      cap = {cap[62:0], mi};
    end
    if (ext) begin
      // one more sample edge landing together with ss rising
      mosi[m] = 1'b1;
      wait_n(H);
      sclk[m] = ~cpol(m);
      ss[m] = 1'b1;
      wait_n(H);
      sclk[m] = cpol(m);
    end else begin
      wait_n(H);
      ss[m] = 1'b1;
      if (lat) begin
        repeat (3) @(posedge clk);
        #1 chk("done_early", rxv[m] | ferr[m], 0);
        @(posedge clk);
        #1 chk("done_latency", rxv[m] | ferr[m], 1);
      end
    end
    wait_n(10);
  endtask

  task automatic run(input string tag, input int m, input int nb, input logic [63:0] d,
                     input logic [TXW-1:0] tx, input bit lat, input bit ext,
                     input bit ev, input bit ee, input int elen, input logic [RXW-1:0] erx);
    int v0, e0, t0;
    logic [63:0] cap, ecap;
    v0 = nv[m]; e0 = ne[m]; t0 = nt[m];
    frame(m, nb, d, tx, lat, ext, cap);
    ecap = '0;
    for (int i = 0; i < nb; i++) ecap = {ecap[62:0], (i < TXW) ? tx[TXW-1-i] : 1'b0};
    chk({tag, "_valid"}, 64'(nv[m] - v0), 64'(ev));
    chk({tag, "_err"},   64'(ne[m] - e0), 64'(ee));
    chk({tag, "_taken"}, 64'(nt[m] - t0), 64'd1);
    chk({tag, "_len"},   64'(rxl[m]), 64'(elen));
    chk({tag, "_data"},  64'(rxd[m]), 64'(erx));
    chk({tag, "_miso"},  cap, ecap);
    if (ev) rxm[m] = erx;
  endtask

  typedef struct {
    int             m;
    int             nb;
    logic [63:0]    d;
    logic [TXW-1:0] tx;
    bit             lat;
    bit             ext;
    bit             ev;
    bit             ee;
    int             elen;
    logic [RXW-1:0] erx;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int v0, e0, t0, nb, m, elen;
    logic mi, ev, ee;
    logic [63:0] d, msk;
    logic [TXW-1:0] tx;
    logic [RXW-1:0] erx;

    tbl[0] = '{0, 56, 64'hA5A50123456789,   48'h123456789ABC, 1, 0, 1, 0, 56, 56'hA5A50123456789};
    tbl[1] = '{0, 40, 64'hDEADBEEF01,       48'hFFFF0000FFFF, 0, 0, 0, 1, 40, 56'hA5A50123456789};
    tbl[2] = '{2, 56, 64'h0F1E2D3C4B5A69,   48'h800000000001, 0, 0, 1, 0, 56, 56'h0F1E2D3C4B5A69};
    tbl[3] = '{1, 60, 64'hFEDCBA987654321,  48'hAAAAAAAAAAAA, 1, 0, 0, 1, 57, 56'h0};
    tbl[4] = '{1, 56, 64'h123456789ABCDE,   48'h555555555555, 0, 0, 1, 0, 56, 56'h123456789ABCDE};
    tbl[5] = '{0, 57, 64'h1FFFFFFFFFFFFFF,  48'h0F0F0F0F0F0F, 0, 0, 0, 1, 57, 56'hA5A50123456789};
    tbl[6] = '{0, 0,  64'h0,                48'hFFFFFFFFFFFF, 0, 0, 0, 1, 0,  56'hA5A50123456789};
    tbl[7] = '{2, 55, 64'h7ABCDEF0123456,   48'hC3C3C3C3C3C3, 0, 0, 0, 1, 55, 56'h0F1E2D3C4B5A69};
    tbl[8] = '{0, 56, 64'h00FF00FF00FF00,   48'h0123456789AB, 0, 1, 1, 0, 56, 56'h00FF00FF00FF00};

    for (int i = 0; i < 3; i++) begin
      sclk[i] = cpol(i); ss[i] = 1'b1; mosi[i] = 1'b0; txd[i] = '0; rxm[i] = '0;
    end

    // reset state
    nrst = 1'b0;
    wait_n(4);
    for (int i = 0; i < 3; i++) begin
      chk("reset_rx_data", 64'(rxd[i]), 64'd0);
      chk("reset_rx_len",  64'(rxl[i]), 64'd0);
      chk("reset_pulses",  64'({rxv[i], ferr[i], tt[i]}), 64'd0);
      chk("reset_miso",    64'(miso[i]), 64'd0);
    end
    nrst = 1'b1;
    wait_n(6);

    for (int i = 0; i < 9; i++)
      run($sformatf("vec%0d", i), tbl[i].m, tbl[i].nb, tbl[i].d, tbl[i].tx, tbl[i].lat,
          tbl[i].ext, tbl[i].ev, tbl[i].ee, tbl[i].elen, tbl[i].erx);

    // reset in the middle of a frame, ss kept low across release
    txd[0] = 48'hCAFEF00DBEEF;
    @(negedge clk);
    ss[0] = 1'b0;
    wait_n(8);
    for (int i = 0; i < 20; i++) sbit(0, 1'($urandom), mi);
    nrst = 1'b0;
    wait_n(3);
    chk("midrst_rx_data", 64'(rxd[0]), 64'd0);
    chk("midrst_rx_len",  64'(rxl[0]), 64'd0);
    nrst = 1'b1;
    v0 = nv[0]; e0 = ne[0]; t0 = nt[0];
    for (int i = 0; i < 8; i++) sbit(0, 1'($urandom), mi);
    wait_n(20);
    chk("midrst_no_valid", 64'(nv[0] - v0), 64'd0);
    chk("midrst_no_err",   64'(ne[0] - e0), 64'd0);
    chk("midrst_no_taken", 64'(nt[0] - t0), 64'd0);
    ss[0] = 1'b1;
    wait_n(10);
    for (int i = 0; i < 3; i++) rxm[i] = '0;
    d = {$urandom, $urandom} & 64'h00FF_FFFF_FFFF_FFFF;
    run("after_rst", 0, 56, d, 48'h13579BDF2468, 0, 0, 1, 0, 56, d[55:0]);

    // random frames against the frame-level model
    for (int r = 0; r < 8; r++) begin
      m  = int'($urandom_range(0, 2));
      nb = ($urandom % 2 == 0) ? RXW : int'($urandom_range(1, 64));
      msk = (nb == 64) ? '1 : ((64'd1 << nb) - 64'd1);
      d  = {$urandom, $urandom} & msk;
      tx = TXW'({$urandom, $urandom});
      ev   = (nb == RXW);
      ee   = !ev;
      elen = (nb > RXW + 1) ? RXW + 1 : nb;
      erx  = ev ? d[RXW-1:0] : rxm[m];
      run($sformatf("rnd%0d", r), m, nb, d, tx, 0, 0, ev, ee, elen, erx);
    end

    chk("pulse_protocol", 64'(prot_bad), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
